// File: rtl/wb_mcu_pkg.sv
// Shared types and helpers for the Wishbone master controller.
package wb_mcu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS   = 2'd1,
    LOCAL = 2'd2
  } state_t;

  localparam logic RD = 1'b0;
  localparam logic WR = 1'b1;

  localparam logic SEL_OFF = 1'b0;
  localparam logic SEL_ON  = 1'b1;

  // Expand one byte-lane select bit into its 8-bit data mask.
  function automatic logic [7:0] lane_mask(input logic sel);
    lane_mask = {8{sel}};
  endfunction

endpackage

// File: rtl/wb_timeout_ctr.sv
// Bus response watchdog; expires on the last allowed cycle without response.
module wb_timeout_ctr #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic expired
);

  generate
    if (TIMEOUT == 0) begin : g_off
      assign expired = 1'b0;
    end else begin : g_on
      localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
      logic [CW-1:0] cnt;

      always_ff @(posedge clk) begin
        if (rst || clr) begin
          cnt <= '0;
        end else if (run) begin
          cnt <= cnt + CW'(1);
        end
      end

      assign expired = run && (cnt == CW'(TIMEOUT - 1));
    end
  endgenerate

endmodule

// File: rtl/wb_master_ctrl.sv
// Wishbone classic master with local PSW alias, bus error and timeout abort.
module wb_master_ctrl
  import wb_mcu_pkg::*;
#(
  parameter int WORD    = 16,
  parameter int ADDR_W  = 15,
  parameter int TIMEOUT = 64
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic                rw_i,
  input  logic                pswAddr_i,
  input  logic [WORD/8-1:0]   sel_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [WORD-1:0]     data_i,
  input  logic [WORD-1:0]     psw_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic                pswWr_o,
  output logic [WORD-1:0]     data_o,
  input  logic                ack_i,
  input  logic                err_i,
  input  logic [WORD-1:0]     dat_i,
  output logic                we_o,
  output logic                stb_o,
  output logic                cyc_o,
  output logic [WORD/8-1:0]   sel_o,
  output logic [ADDR_W-1:0]   adr_o,
  output logic [WORD-1:0]     dat_o
);

  localparam int LANES = WORD / 8;

  state_t state, state_nx;

  logic            rw_q;
  logic            accept;
  logic            on_bus;
  logic            on_local;
  logic            resp;
  logic            expired;
  logic [WORD-1:0] mask;

  assign busy_o   = (state != IDLE);
  assign accept   = en_i & ~busy_o;
  assign on_bus   = (state == BUS);
  assign on_local = (state == LOCAL);
  assign resp     = ack_i | err_i;

  assign cyc_o   = on_bus;
  assign stb_o   = on_bus;
  assign we_o    = on_bus & (rw_q == WR);
  assign pswWr_o = on_local & (rw_q == WR);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign mask[8*i +: 8] = lane_mask(sel_o[i]);
  end

  wb_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_tmo (
    .clk    (clk_i),
    .rst    (rst_i),
    .clr    (accept),
    .run    (on_bus & ~resp),
    .expired(expired)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (accept && pswAddr_i) begin
          state_nx = LOCAL;
        end else if (accept && (sel_i != '0)) begin
          state_nx = BUS;
        end
      end
      BUS: begin
        if (resp || expired) begin
          state_nx = IDLE;
        end
      end
      LOCAL:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // err_i beats a simultaneous ack_i; an empty lane select aborts at accept.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      rw_q   <= RD;
      sel_o  <= '0;
      adr_o  <= '0;
      dat_o  <= '0;
      data_o <= '0;
    end else begin
      done_o <= (on_bus & ack_i & ~err_i) | on_local;
      err_o  <= (on_bus & (err_i | expired))
              | (accept & ~pswAddr_i & (sel_i == '0));
      if (accept) begin
        rw_q  <= rw_i;
        sel_o <= sel_i;
        adr_o <= addr_i;
        dat_o <= data_i;
      end
      if (on_bus && ack_i && !err_i && rw_q == RD) begin
        data_o <= dat_i & mask;
      end else if (on_local && rw_q == RD) begin
        data_o <= psw_i & mask;
      end
    end
  end

endmodule

// File: tb/tb_wb_master_ctrl.sv
// Scoreboard bench for wb_master_ctrl with a scripted Wishbone slave.
module tb_wb_master_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        en_i = 1'b0;
  logic        rw_i = 1'b0;
  logic        pswAddr_i = 1'b0;
  logic [1:0]  sel_i = 2'b00;
  logic [14:0] addr_i = '0;
  logic [15:0] data_i = '0;
  logic [15:0] psw_i = '0;
  logic        busy_o, done_o, err_o, pswWr_o;
  logic [15:0] data_o;
  logic        ack_i = 1'b0;
  logic        err_i = 1'b0;
  logic [15:0] dat_i = '0;
  logic        we_o, stb_o, cyc_o;
  logic [1:0]  sel_o;
  logic [14:0] adr_o;
  logic [15:0] dat_o;

  wb_master_ctrl #(
    .WORD(16), .ADDR_W(15), .TIMEOUT(TO)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .rw_i(rw_i),
    .pswAddr_i(pswAddr_i), .sel_i(sel_i), .addr_i(addr_i),
    .data_i(data_i), .psw_i(psw_i), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o), .pswWr_o(pswWr_o),
    .data_o(data_o), .ack_i(ack_i), .err_i(err_i), .dat_i(dat_i),
    .we_o(we_o), .stb_o(stb_o), .cyc_o(cyc_o), .sel_o(sel_o),
    .adr_o(adr_o), .dat_o(dat_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    logic [15:0] data;
    int          cyc_len;
    int          psw_wr;
    logic        we;
    logic [15:0] dat;
    logic [14:0] adr;
    logic [1:0]  sel;
  } exp_t;

  exp_t        q[$];
  logic [15:0] model = '0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc_run = 0;
  int          psw_run = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic logic [15:0] steer(input logic [15:0] src,
                                        input logic [1:0] sel);
    logic [15:0] r;
    r[7:0]  = sel[0] ? src[7:0]  : 8'h00;
    r[15:8] = sel[1] ? src[15:8] : 8'h00;
    return r;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_i) begin
      cyc_run = 0;
      psw_run = 0;
    end else begin
      if (cyc_o) begin
        cyc_run++;
        chk("stb_eq_cyc", stb_o, cyc_o);
        if (q.size() > 0) begin
          chk("we_o", we_o, q[0].we);
          chk("dat_o", dat_o, q[0].dat);
          chk("adr_o", adr_o, q[0].adr);
          chk("sel_o", sel_o, q[0].sel);
        end
      end
      if (pswWr_o) begin
        psw_run++;
        if (q.size() > 0) chk("psw_dat", dat_o, q[0].dat);
      end
      if (done_o || err_o) begin
        if (q.size() == 0) begin
          chk("spurious", {done_o, err_o}, 2'b00);
        end else begin
          e = q.pop_front();
          chk("kind", {done_o, err_o}, e.is_err ? 2'b01 : 2'b10);
          chk("data_o", data_o, e.data);
          chk("cyc_len", cyc_run, e.cyc_len);
          chk("psw_wr", psw_run, e.psw_wr);
          chk("busy_at_pulse", busy_o, 1'b0);
        end
        cyc_run = 0;
        psw_run = 0;
      end
    end
  end

  task automatic xfer(input logic rw, input logic psw,
                      input logic [1:0] sel, input logic [14:0] addr,
                      input logic [15:0] wdat, input int resp_at,
                      input logic r_ack, input logic r_err,
                      input logic [15:0] sdat, input logic [15:0] pswv,
                      input bit poke);
    exp_t e;
    int   k;
    e.we = rw; e.dat = wdat; e.adr = addr; e.sel = sel;
    e.psw_wr = 0; e.cyc_len = 0; e.is_err = 1'b0;
    if (psw) begin
      e.psw_wr = rw ? 1 : 0;
      if (!rw) model = steer(pswv, sel);
    end else if (sel == 2'b00) begin
      e.is_err = 1'b1;
    end else if (resp_at == 0 || resp_at > TO) begin
      e.is_err = 1'b1;
      e.cyc_len = TO;
    end else begin
      e.cyc_len = resp_at;
      if (r_err) e.is_err = 1'b1;
      else if (!rw) model = steer(sdat, sel);
    end
    e.data = model;
    q.push_back(e);
    @(negedge clk);
    en_i = 1'b1; rw_i = rw; pswAddr_i = psw; sel_i = sel;
    addr_i = addr; data_i = wdat; psw_i = pswv; dat_i = sdat;
    @(negedge clk);
    en_i = 1'b0; data_i = ~wdat; addr_i = ~addr; sel_i = ~sel;
    k = 1;
    while (cyc_o && k <= 20) begin
      if (poke && k == 1) begin
        en_i = 1'b1; pswAddr_i = 1'b1; rw_i = 1'b1;
      end else begin
        en_i = 1'b0;
      end
      ack_i = (k == resp_at) & r_ack;
      err_i = (k == resp_at) & r_err;
      @(negedge clk);
      k++;
    end
    en_i = 1'b0; ack_i = 1'b0; err_i = 1'b0;
    if (k > 20) chk("bus_bound", cyc_o, 1'b0);
    repeat (3) @(negedge clk);
    chk("drain", q.size(), 0);
    q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ctl", {busy_o, done_o, err_o, pswWr_o, we_o, cyc_o, stb_o}, 7'b0);
    chk("rst_bus", {sel_o, adr_o, dat_o}, 33'b0);
    chk("rst_data", data_o, 16'h0000);
    rst_i = 1'b0;
    @(negedge clk);

    // write, slave acks on the 3rd bus cycle
    xfer(1'b1, 1'b0, 2'b11, 15'h1234, 16'hBEEF, 3, 1'b1, 1'b0,
         16'h0000, 16'h0000, 1'b0);
    // lane-steered reads; en_i during busy must be ignored
    xfer(1'b0, 1'b0, 2'b01, 15'h0040, 16'h0000, 1, 1'b1, 1'b0,
         16'hA55A, 16'h0000, 1'b1);
    chk("read_lo", data_o, 16'h005A);
    xfer(1'b0, 1'b0, 2'b10, 15'h0041, 16'h0000, 1, 1'b1, 1'b0,
         16'hA55A, 16'h0000, 1'b0);
    chk("read_hi", data_o, 16'hA500);
    // no response: timeout after TO cycles
    xfer(1'b0, 1'b0, 2'b11, 15'h0050, 16'h0000, 0, 1'b0, 1'b0,
         16'h1111, 16'h0000, 1'b0);
    // ack and err together: error wins
    xfer(1'b0, 1'b0, 2'b11, 15'h0051, 16'h0000, 2, 1'b1, 1'b1,
         16'hFFFF, 16'h0000, 1'b0);
    // ack on the last allowed cycle beats the timeout
    xfer(1'b0, 1'b0, 2'b11, 15'h0052, 16'h0000, TO, 1'b1, 1'b0,
         16'h1357, 16'h0000, 1'b0);
    // error-only on a write
    xfer(1'b1, 1'b0, 2'b11, 15'h0053, 16'h4242, 1, 1'b0, 1'b1,
         16'h0000, 16'h0000, 1'b0);
    // PSW write and reads
    xfer(1'b1, 1'b1, 2'b11, 15'h0000, 16'h00F0, 0, 1'b0, 1'b0,
         16'h0000, 16'h0000, 1'b0);
    xfer(1'b0, 1'b1, 2'b11, 15'h0000, 16'h0000, 0, 1'b0, 1'b0,
         16'h0000, 16'h0013, 1'b0);
    xfer(1'b0, 1'b1, 2'b10, 15'h0000, 16'h0000, 0, 1'b0, 1'b0,
         16'h0000, 16'hABCD, 1'b0);
    // empty lane select aborts without a bus cycle
    xfer(1'b0, 1'b0, 2'b00, 15'h0060, 16'h0000, 1, 1'b1, 1'b0,
         16'h9999, 16'h0000, 1'b0);

    // reset on the 2nd bus cycle
    @(negedge clk);
    en_i = 1'b1; rw_i = 1'b1; pswAddr_i = 1'b0; sel_i = 2'b11;
    addr_i = 15'h0111; data_i = 16'h7777;
    @(negedge clk);
    en_i = 1'b0;
    @(negedge clk);
    chk("pre_rst_cyc", cyc_o, 1'b1);
    rst_i = 1'b1;
    @(negedge clk);
    chk("mid_rst_ctl", {busy_o, done_o, err_o, we_o, cyc_o, stb_o}, 6'b0);
    chk("mid_rst_bus", {sel_o, adr_o, dat_o}, 33'b0);
    chk("mid_rst_data", data_o, 16'h0000);
    rst_i = 1'b0;
    model = 16'h0000;
    repeat (3) @(negedge clk);
    xfer(1'b0, 1'b0, 2'b11, 15'h0200, 16'h0000, 2, 1'b1, 1'b0,
         16'h2468, 16'h0000, 1'b0);
    chk("post_rst_read", data_o, 16'h2468);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
